// File: rtl/timer_mode_ctrl_if.sv
// Bus between the timer sequencing FSM and its surrounding datapath.
// The controller sits on the slave side; the datapath/driver sits on the master side.
interface timer_mode_ctrl_if #(
    parameter int unsigned CNT_W = 13
);
    logic             ModeSel;
    logic [2:0]       TimeControl;
    logic             resetter;
    logic             start_stop;
    logic             tick;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_clr;
    logic             cnt_load;
    logic [CNT_W-1:0] load_value;
    logic             cnt_en;
    logic             cnt_dir;
    logic             alarm;
    logic             ovf;
    logic [1:0]       state;

    modport slave (
        input  ModeSel, TimeControl, resetter, start_stop, tick, cnt_val,
        output cnt_clr, cnt_load, load_value, cnt_en, cnt_dir, alarm, ovf, state
    );

    modport master (
        output ModeSel, TimeControl, resetter, start_stop, tick, cnt_val,
        input  cnt_clr, cnt_load, load_value, cnt_en, cnt_dir, alarm, ovf, state
    );
endinterface

// File: rtl/timer_mode_ctrl.sv
// Sequencing FSM for a two-mode seconds timer: stopwatch up-count (Mode A)
// and preset countdown with a timed alarm (Mode B).
module timer_mode_ctrl #(
    parameter int unsigned CNT_W       = 13,
    parameter int unsigned MAX_COUNT   = 5999,
    parameter int unsigned PRESET_UNIT = 30,
    parameter int unsigned ALARM_TICKS = 5
) (
    input logic              clk,
    input logic              rst,
    timer_mode_ctrl_if.slave bus
);
    localparam int unsigned ATW = $clog2(ALARM_TICKS + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StAlarm = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             clr_q, clr_d;
    logic             load_q, load_d;
    logic             alarm_q, alarm_d;
    logic             ovf_q, ovf_d;
    logic [ATW-1:0]   atick_q, atick_d;
    logic             at_max, at_zero, gate, en;
    logic [31:0]      preset;

    always_comb begin
        at_max  = (bus.cnt_val == CNT_W'(MAX_COUNT));
        at_zero = (bus.cnt_val == '0);
        // Counter already at its terminal value for the current direction
        gate    = (~bus.ModeSel & at_max) | (bus.ModeSel & at_zero);
        en      = bus.tick & (state_q == StRun) & ~gate;
        preset  = (32'(bus.TimeControl) + 32'd1) * 32'(PRESET_UNIT);
    end

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        load_d  = 1'b0;
        alarm_d = alarm_q;
        ovf_d   = ovf_q;
        atick_d = atick_q;

        if (bus.resetter) begin
            state_d = StIdle;
            alarm_d = 1'b0;
            ovf_d   = 1'b0;
            atick_d = '0;
            clr_d   = ~bus.ModeSel;
            load_d  = bus.ModeSel;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_stop) state_d = StRun;
                end
                StRun: begin
                    if (bus.start_stop) begin
                        state_d = StPause;
                    end else if (!bus.ModeSel && bus.tick && at_max) begin
                        state_d = StPause;
                        ovf_d   = 1'b1;
                    end else if (bus.ModeSel && (at_zero || (bus.tick &&
                                 bus.cnt_val == CNT_W'(1)))) begin
                        state_d = StAlarm;
                        alarm_d = 1'b1;
                        atick_d = '0;
                    end
                end
                StPause: begin
                    if (bus.start_stop && !gate) state_d = StRun;
                end
                StAlarm: begin
                    if (bus.start_stop ||
                        (bus.tick && atick_q == ATW'(ALARM_TICKS - 1))) begin
                        state_d = StIdle;
                        alarm_d = 1'b0;
                        load_d  = 1'b1;
                        atick_d = '0;
                    end else if (bus.tick) begin
                        atick_d = atick_q + ATW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            clr_q   <= 1'b0;
            load_q  <= 1'b0;
            alarm_q <= 1'b0;
            ovf_q   <= 1'b0;
            atick_q <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            load_q  <= load_d;
            alarm_q <= alarm_d;
            ovf_q   <= ovf_d;
            atick_q <= atick_d;
        end
    end

    assign bus.cnt_clr    = clr_q;
    assign bus.cnt_load   = load_q;
    assign bus.load_value = CNT_W'(preset);
    assign bus.cnt_en     = en;
    assign bus.cnt_dir    = ~bus.ModeSel;
    assign bus.alarm      = alarm_q;
    assign bus.ovf        = ovf_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Scoreboard bench for timer_mode_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares every event the controller presents.
module tb_timer_mode_ctrl;
    localparam int unsigned CNT_W = 13;

    localparam logic [1:0] KSt   = 2'd0;
    localparam logic [1:0] KClr  = 2'd1;
    localparam logic [1:0] KLoad = 2'd2;
    localparam logic [1:0] KEn   = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_on = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    logic [3:0] prev_st = 4'd0;

    timer_mode_ctrl_if #(.CNT_W(CNT_W)) ifc ();

    timer_mode_ctrl #(
        .CNT_W      (CNT_W),
        .MAX_COUNT  (5999),
        .PRESET_UNIT(30),
        .ALARM_TICKS(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ex(input logic [1:0] k, input logic [15:0] v);
        exp_q.push_back('{kind: k, val: v});
    endtask

    task automatic ex_st(input logic o, input logic a, input logic [1:0] s);
        ex(KSt, {12'd0, o, a, s});
    endtask

    task automatic observe(input logic [1:0] k, input logic [15:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0d expected none at %0t",
                     k, v, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.val !== v) begin
                errors++;
                $display("FAIL event: got kind %0d val %0d expected kind %0d val %0d at %0t",
                         k, v, e.kind, e.val, $time);
            end
        end
    endtask

    // Event order per cycle: state change, clear, load, enable
    always @(negedge clk) begin
        logic [3:0] cur;
        if (mon_on) begin
            cur = {ifc.ovf, ifc.alarm, ifc.state};
            if (cur !== prev_st) begin
                observe(KSt, {12'd0, cur});
                prev_st = cur;
            end
            if (ifc.cnt_clr)  observe(KClr, 16'd0);
            if (ifc.cnt_load) observe(KLoad, 16'(ifc.load_value));
            if (ifc.cnt_en)   observe(KEn, {15'd0, ifc.cnt_dir});
        end
    end

    task automatic step(input logic r, input logic s, input logic t);
        ifc.resetter   = r;
        ifc.start_stop = s;
        ifc.tick       = t;
        @(posedge clk);
        #1;
        ifc.resetter   = 1'b0;
        ifc.start_stop = 1'b0;
        ifc.tick       = 1'b0;
    endtask

    initial begin
        ifc.ModeSel     = 1'b0;
        ifc.TimeControl = 3'd0;
        ifc.resetter    = 1'b0;
        ifc.start_stop  = 1'b0;
        ifc.tick        = 1'b0;
        ifc.cnt_val     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {14'd0, ifc.state}, 16'd0);
        chk("rst_clr", {15'd0, ifc.cnt_clr}, 16'd0);
        chk("rst_load", {15'd0, ifc.cnt_load}, 16'd0);
        chk("rst_en", {15'd0, ifc.cnt_en}, 16'd0);
        chk("rst_alarm", {15'd0, ifc.alarm}, 16'd0);
        chk("rst_ovf", {15'd0, ifc.ovf}, 16'd0);
        rst = 1'b0;
        mon_on = 1'b1;

        // Mode B preset load and three countdown ticks
        ifc.ModeSel     = 1'b1;
        ifc.TimeControl = 3'b001;
        ifc.cnt_val     = 13'd60;
        ex(KLoad, 16'd60);
        step(1'b1, 1'b0, 1'b0);
        ex_st(1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ex(KEn, 16'd0);
            step(1'b0, 1'b0, 1'b1);
            ifc.cnt_val = ifc.cnt_val - 13'd1;
        end

        // Expiry into ALARM, auto exit on fifth alarm tick
        ifc.cnt_val = 13'd1;
        ex(KEn, 16'd0);
        ex_st(1'b0, 1'b1, 2'd3);
        step(1'b0, 1'b0, 1'b1);
        ifc.cnt_val = 13'd0;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        ex_st(1'b0, 1'b0, 2'd0);
        ex(KLoad, 16'd60);
        step(1'b0, 1'b0, 1'b1);
        ifc.cnt_val = 13'd60;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // ALARM exit through start_stop
        ex_st(1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0);
        ifc.cnt_val = 13'd1;
        ex(KEn, 16'd0);
        ex_st(1'b0, 1'b1, 2'd3);
        step(1'b0, 1'b0, 1'b1);
        ifc.cnt_val = 13'd0;
        step(1'b0, 1'b0, 1'b1);
        ex_st(1'b0, 1'b0, 2'd0);
        ex(KLoad, 16'd60);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // RUN with counter already at zero: ALARM without enable, full tick count again
        ex_st(1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0);
        ex_st(1'b0, 1'b1, 2'd3);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        ex_st(1'b0, 1'b0, 2'd0);
        ex(KLoad, 16'd60);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Mode A saturation, sticky ovf, start_stop ignored while gated
        ifc.ModeSel = 1'b0;
        ex(KClr, 16'd0);
        step(1'b1, 1'b0, 1'b0);
        ex_st(1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0);
        ifc.cnt_val = 13'd5998;
        ex(KEn, 16'd1);
        step(1'b0, 1'b0, 1'b1);
        ifc.cnt_val = 13'd5999;
        ex_st(1'b1, 1'b0, 2'd2);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        ex_st(1'b0, 1'b0, 2'd0);
        ex(KClr, 16'd0);
        step(1'b1, 1'b0, 1'b0);
        ifc.cnt_val = 13'd0;
        step(1'b0, 1'b0, 1'b0);

        // resetter beats start_stop in the same cycle
        ex_st(1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        ex_st(1'b0, 1'b0, 2'd0);
        ex(KClr, 16'd0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        // tick and start_stop together in RUN, then resume and pause again
        ex_st(1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0);
        ifc.cnt_val = 13'd10;
        ex(KEn, 16'd1);
        ex_st(1'b0, 1'b0, 2'd2);
        step(1'b0, 1'b1, 1'b1);
        ifc.cnt_val = 13'd11;
        step(1'b0, 1'b0, 1'b0);
        ex_st(1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0);
        ex_st(1'b0, 1'b0, 2'd2);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending expected 0", exp_q.size());
        end
        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
